muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Multiply support (MULT/MULTU) is built only when MULDIV_MULT_EN is defined.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  cnt_q;
  logic [31:0] acc_q;    // remainder (divide) / product high half (multiply)
  logic [31:0] sh_q;     // dividend->quotient (divide) / multiplier->product low half
  logic [31:0] opnd_q;   // divisor magnitude / multiplicand magnitude
  logic        neg_lo_q; // negate quotient or whole product at the end
  logic        neg_hi_q; // negate remainder at the end
  logic [31:0] hi_q, lo_q;
`ifdef MULDIV_MULT_EN
  logic        is_mul_q;
`endif

  logic        op_ok;
  logic        launch;
  logic        signed_op, rs_neg, rt_neg, rt_zero;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [31:0] step_acc, step_sh;
  logic [31:0] res_hi, res_lo;
  logic [31:0] quo_res, rem_res;

`ifdef MULDIV_MULT_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op_i[1];
`endif

  assign launch    = (state_q == S_IDLE) && start_i && op_ok;
  assign signed_op = op_i[0];
  assign rs_neg    = signed_op & rs_i[31];
  assign rt_neg    = signed_op & rt_i[31];
  assign rs_mag    = rs_neg ? (~rs_i + 32'd1) : rs_i;
  assign rt_mag    = rt_neg ? (~rt_i + 32'd1) : rt_i;
  assign rt_zero   = (rt_i == 32'd0);

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  assign rem_sh   = {acc_q, sh_q[31]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
  assign div_ge   = ~div_diff[33];

  assign quo_res = neg_lo_q ? (~sh_q + 32'd1) : sh_q;
  assign rem_res = neg_hi_q ? (~acc_q + 32'd1) : acc_q;

`ifdef MULDIV_MULT_EN
  logic [32:0] mul_sum;
  logic [63:0] prod, prod_res;
  assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign prod     = {acc_q, sh_q};
  assign prod_res = neg_lo_q ? (~prod + 64'd1) : prod;

  always_comb begin
    step_acc = div_ge ? div_diff[31:0] : rem_sh[31:0];
    step_sh  = {sh_q[30:0], div_ge};
    res_hi   = rem_res;
    res_lo   = quo_res;
    if (is_mul_q) begin
      step_acc = mul_sum[32:1];
      step_sh  = {mul_sum[0], sh_q[31:1]};
      res_hi   = prod_res[63:32];
      res_lo   = prod_res[31:0];
    end
  end
`else
  always_comb begin
    step_acc = div_ge ? div_diff[31:0] : rem_sh[31:0];
    step_sh  = {sh_q[30:0], div_ge};
    res_hi   = rem_res;
    res_lo   = quo_res;
  end
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_RUN;
      S_RUN:   if (cnt_q == 5'd31) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs (registered on the next edge)
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_IDLE:  busy_d = launch;
      S_RUN:   busy_d = 1'b1;
      S_FIN:   done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // Datapath. A zero divisor suppresses quotient negation so LO ends all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 5'd0;
      acc_q    <= 32'd0;
      sh_q     <= 32'd0;
      opnd_q   <= 32'd0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`ifdef MULDIV_MULT_EN
      is_mul_q <= 1'b0;
`endif
    end else if (launch) begin
      cnt_q    <= 5'd0;
      acc_q    <= 32'd0;
`ifdef MULDIV_MULT_EN
      is_mul_q <= op_i[1];
      sh_q     <= op_i[1] ? rt_mag : rs_mag;
      opnd_q   <= op_i[1] ? rs_mag : rt_mag;
      neg_lo_q <= (rs_neg ^ rt_neg) & (op_i[1] | ~rt_zero);
      neg_hi_q <= rs_neg & ~op_i[1];
`else
      sh_q     <= rs_mag;
      opnd_q   <= rt_mag;
      neg_lo_q <= (rs_neg ^ rt_neg) & ~rt_zero;
      neg_hi_q <= rs_neg;
`endif
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + 5'd1;
      acc_q <= step_acc;
      sh_q  <= step_sh;
    end
  end

  // HI/LO: moves only in IDLE; a result written in FIN overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state_q == S_FIN) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (state_q == S_IDLE) begin
      if (mthi_i) hi_q <= wdata_i;
      if (mtlo_i) lo_q <= wdata_i;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected {HI,LO};
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i, rt_i, wdata_i;
  logic        mthi_i, mtlo_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o), .state_o(state_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && done_o) begin
      check("busy_done_exclusive", 64'(busy_o), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done hi=%h lo=%h", hi_o, lo_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_hi_lo", {hi_o, lo_o}, mon_exp);
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic move(input bit w_hi, input bit w_lo, input logic [31:0] d);
    @(negedge clk);
    mthi_i = w_hi; mtlo_i = w_lo; wdata_i = d;
    @(posedge clk); #1;
    mthi_i = 1'b0; mtlo_i = 1'b0;
  endtask

  // Launch one operation, optionally poke start/mtlo mid-run, and check latency.
  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [63:0] exp, input bit disturb);
    int n;
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      if (disturb && n == 5) begin
        start_i = 1'b1; op_i = 2'b00; rs_i = 32'd9; rt_i = 32'd3;
        mtlo_i = 1'b1; wdata_i = 32'h0000AAAA;
      end else begin
        start_i = 1'b0; mtlo_i = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0; mtlo_i = 1'b0;
    check("busy_cycles", 64'(n), 64'd33);
    check("done_pulse", 64'(done_o), 64'd1);
    @(posedge clk); #1;
    check("done_busy_low_after", {62'd0, done_o, busy_o}, 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; rs_i = '0; rt_i = '0;
    mthi_i = 1'b0; mtlo_i = 1'b0; wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi_lo", {hi_o, lo_o}, 64'd0);
    check("reset_busy_done_state", {60'd0, busy_o, done_o, state_o}, 64'd0);
    rst = 1'b0;

    run_op(2'b00, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    run_op(2'b01, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0);
    run_op(2'b01, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0);
    run_op(2'b00, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, 1'b1);
    check("lo_after_ignored_mtlo", 64'(lo_o), 64'hFFFFFFFF);
    run_op(2'b01, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF}, 1'b0);

    move(1'b1, 1'b0, 32'hDEADBEEF);
    check("mthi_visible", 64'(hi_o), 64'hDEADBEEF);
    move(1'b0, 1'b1, 32'h5);
    check("mtlo_visible", {hi_o, lo_o}, {32'hDEADBEEF, 32'h5});
    move(1'b1, 1'b1, 32'h00C0FFEE);
    check("mthi_mtlo_both", {hi_o, lo_o}, {32'h00C0FFEE, 32'h00C0FFEE});

    // same-cycle start and MTHI: move lands, result later overwrites
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; rs_i = 32'd100; rt_i = 32'd7;
    mthi_i = 1'b1; wdata_i = 32'h1111;
    exp_q.push_back({32'd2, 32'd14});
    @(posedge clk); #1;
    start_i = 1'b0; mthi_i = 1'b0;
    check("start_with_mthi", {hi_o, lo_o}, {32'h1111, 32'h00C0FFEE});
    check("start_with_mthi_busy", 64'(busy_o), 64'd1);
    n = 0;
    while (!done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_with_mthi_latency", 64'(n), 64'd33);
    @(posedge clk); #1;

    // reset in the middle of a run
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; rs_i = 32'd100; rt_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_reset_hi_lo", {hi_o, lo_o}, 64'd0);
    check("midrun_reset_ctrl", {60'd0, busy_o, done_o, state_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("midrun_reset_idle", {61'd0, busy_o, state_o}, 64'd0);

`ifdef MULDIV_MULT_EN
    run_op(2'b11, 32'hFFFFFFFD, 32'd5, {32'hFFFFFFFF, 32'hFFFFFFF1}, 1'b0);
    run_op(2'b10, 32'hFFFFFFFF, 32'd2, {32'd1, 32'hFFFFFFFE}, 1'b0);
`else
    move(1'b1, 1'b1, 32'h00000077);
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b11; rs_i = 32'hFFFFFFFD; rt_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_o) n++;
      @(posedge clk); #1;
    end
    check("mult_disabled_busy", 64'(n), 64'd0);
    check("mult_disabled_hi_lo", {hi_o, lo_o}, {32'h77, 32'h77});
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
